// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, computed LSB-first with one borrow flip-flop.
// Optional signed-overflow output is enabled by defining BIT_SERIAL_SUB_OVF_EN.
`timescale 1ns/1ps
module bit_serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
`ifdef BIT_SERIAL_SUB_OVF_EN
    output logic             done,
    output logic             ovf
`else
    output logic             done
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sreg_a;
    logic [WIDTH-1:0] r_sreg_b;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_count;
    logic             r_borrow;
    logic             r_bout;
    logic             r_done;
    logic             w_d;
    logic             w_borrow_next;
    logic             w_last;

    assign w_d           = r_sreg_a[0] ^ r_sreg_b[0] ^ r_borrow;
    assign w_borrow_next = (~r_sreg_a[0] & r_sreg_b[0]) | (~(r_sreg_a[0] ^ r_sreg_b[0]) & r_borrow);
    assign w_last        = (r_count == CW'(WIDTH - 1));

`ifdef BIT_SERIAL_SUB_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    // On the final shift w_d is the result MSB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (clr) begin
            r_ovf   <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_ovf   <= 1'b0;
        end else if (r_state == SHIFT && w_last) begin
            r_ovf   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        end
    end

    assign ovf = r_ovf;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_sreg_a <= '0;
            r_sreg_b <= '0;
            r_diff   <= '0;
            r_count  <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_done   <= 1'b0;
        end else if (clr) begin
            r_state  <= IDLE;
            r_sreg_a <= '0;
            r_sreg_b <= '0;
            r_diff   <= '0;
            r_count  <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sreg_a <= a;
                        r_sreg_b <= b;
                        r_diff   <= '0;
                        r_count  <= '0;
                        r_borrow <= 1'b0;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_diff   <= {w_d, r_diff[WIDTH-1:1]};
                    r_sreg_a <= {1'b0, r_sreg_a[WIDTH-1:1]};
                    r_sreg_b <= {1'b0, r_sreg_b[WIDTH-1:1]};
                    r_borrow <= w_borrow_next;
                    r_count  <= r_count + 1'b1;
                    if (w_last) begin
                        r_bout  <= w_borrow_next;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;
    assign busy = (r_state == SHIFT);
    assign done = r_done;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed self-checking bench for bit_serial_subtractor (WIDTH=8).
`timescale 1ns/1ps
module tb_bit_serial_subtractor;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       clr;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bout;
    logic       busy;
    logic       done;
`ifdef BIT_SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bit_serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .clr   (clr),
        .a     (a),
        .b     (b),
        .diff  (diff),
        .bout  (bout),
        .busy  (busy),
`ifdef BIT_SERIAL_SUB_OVF_EN
        .done  (done),
        .ovf   (ovf)
`else
        .done  (done)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One operation: accept at edge 0, then sample #1 after edges 0..11.
    // inj >= 0 drives a second start (a=5, b=3) after that edge while busy.
    task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic [7:0] ed, input logic eb, input logic eo, input int inj);
        int bc;
        int dc;
        bc = 0;
        dc = 0;
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = ~ia; b = ~ib;
        for (int i = 0; i < 12; i++) begin
            bc += int'(busy);
            dc += int'(done);
            if (i == inj) begin
                a = 8'd5; b = 8'd3; start = 1'b1;
            end else if (i == inj + 1) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk({tag, "_diff"}, 32'(diff), 32'(ed));
        chk({tag, "_bout"}, 32'(bout), 32'(eb));
        chk({tag, "_busy_cycles"}, 32'(bc), 32'd8);
        chk({tag, "_done_pulses"}, 32'(dc), 32'd1);
`ifdef BIT_SERIAL_SUB_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) chk({tag, "_eo"}, 32'(eo), 32'd0);
`endif
    endtask

    initial begin
        int dc;
        int bc;
        int nd;
        int last;
        reset = 1'b0; start = 1'b0; clr = 1'b0; a = '0; b = '0;
        #1;
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);

        run_op("borrow_15_34",  8'd15,  8'd34, 8'd237, 1'b1, 1'b0, -1);
        run_op("nob_34_15",     8'd34,  8'd15, 8'd19,  1'b0, 1'b0, -1);
        run_op("ovf_129_30",    8'd129, 8'd30, 8'd99,  1'b0, 1'b1, -1);
        run_op("zero_0_0",      8'd0,   8'd0,  8'd0,   1'b0, 1'b0, -1);
        run_op("wrap_0_1",      8'd0,   8'd1,  8'd255, 1'b1, 1'b0, -1);
        run_op("start_busy",    8'd15,  8'd34, 8'd237, 1'b1, 1'b0, 3);

        // Asynchronous reset mid-operation (bout is 1 from the previous run)
        @(negedge clk); a = 8'd15; b = 8'd34; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_partial", 32'(diff), 32'hD0);
        #2; reset = 1'b0; #1;
        chk("arst_diff", 32'(diff), 32'd0);
        chk("arst_bout", 32'(bout), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(negedge clk); reset = 1'b1;
        dc = 0;
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; dc += int'(done); end
        chk("arst_no_done", 32'(dc), 32'd0);

        // clr at shift cycle 5
        run_op("pre_clr", 8'd0, 8'd1, 8'd255, 1'b1, 1'b0, -1);
        @(negedge clk); a = 8'd15; b = 8'd34; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
        clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        chk("clr_diff", 32'(diff), 32'd0);
        chk("clr_bout", 32'(bout), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        dc = 0;
        for (int i = 0; i < 10; i++) begin dc += int'(done); @(posedge clk); #1; end
        chk("clr_no_done", 32'(dc), 32'd0);

        // clr and start together in IDLE
        run_op("pre_prio", 8'd0, 8'd1, 8'd255, 1'b1, 1'b0, -1);
        @(negedge clk); a = 8'd200; b = 8'd100; start = 1'b1; clr = 1'b1;
        @(posedge clk); #1; start = 1'b0; clr = 1'b0;
        chk("prio_diff", 32'(diff), 32'd0);
        chk("prio_bout", 32'(bout), 32'd0);
        bc = 0;
        for (int i = 0; i < 10; i++) begin bc += int'(busy); @(posedge clk); #1; end
        chk("prio_no_busy", 32'(bc), 32'd0);

        // Back-to-back with start held high
        @(negedge clk); a = 8'd200; b = 8'd100; start = 1'b1;
        nd = 0; last = -1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) begin
                chk("b2b_diff", 32'(diff), 32'd100);
                chk("b2b_bout", 32'(bout), 32'd0);
`ifdef BIT_SERIAL_SUB_OVF_EN
                chk("b2b_ovf", 32'(ovf), 32'd1);
`endif
                if (last >= 0) chk("b2b_interval", 32'(i - last), 32'd9);
                else chk("b2b_first", 32'(i), 32'd8);
                last = i;
                nd++;
            end
        end
        chk("b2b_count", 32'(nd), 32'd3);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin @(posedge clk); #1; end
        chk("final_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
